// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the instruction/data port arbiter.
// Handshake: the master holds mem_req, mem_we, mem_addr and mem_wdata stable
// for the whole access; the slave completes it by raising mem_ack for one
// clock edge (mem_rdata valid with it for reads). mem_ack may already be high
// in the first request cycle, and is meaningless while mem_req is low.
interface mem_port_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM-stage
// data access. Every pipeline step is one round: optional data access, then
// the fetch, then a single pipe_run cycle. An access that waits too long for
// mem_ack is abandoned and flagged through the sticky timeout output.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] if_rdata,
  output logic [31:0] d_rdata,
  output logic        pipe_run,
  output logic        timeout,
  output logic [1:0]  dbg_state,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_DECIDE = 2'd0,
    S_DATA   = 2'd1,
    S_INSTR  = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;

  // Request snapshot taken in S_DECIDE; live inputs are ignored afterwards.
  logic [31:0] if_addr_q;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic        wr_q;
  logic        rd_q;
  logic [7:0]  wait_cnt;

  logic        acc_active;
  logic        last_wait;
  logic        acc_done;
  logic        acc_abandon;

  assign dbg_state = state;
  assign pipe_run  = (state == S_RUN);

  // Access completion: an ack, or the wait budget running out.
  always_comb begin
    acc_active  = (state == S_DATA) || (state == S_INSTR);
    last_wait   = (wait_cnt == LAST_WAIT);
    acc_done    = acc_active && (bus.mem_ack || last_wait);
    acc_abandon = acc_active && !bus.mem_ack && last_wait;
  end

  // Next-state decode for the round sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_DECIDE: state_nxt = (d_read || d_write) ? S_DATA : S_INSTR;
      S_DATA:   if (acc_done) state_nxt = S_INSTR;
      S_INSTR:  if (acc_done) state_nxt = S_RUN;
      S_RUN:    state_nxt = S_DECIDE;
      default:  state_nxt = S_DECIDE;
    endcase
  end

  // Memory bus decoded from state and the snapshot only, so it never follows
  // the live pipeline inputs.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      S_DATA: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = wr_q;
        bus.mem_addr  = d_addr_q;
        bus.mem_wdata = d_wdata_q;
      end
      S_INSTR: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = if_addr_q;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_DECIDE;
    else     state <= state_nxt;
  end

  // Snapshot, wait counter, returned data and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_addr_q <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wait_cnt  <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_DECIDE: begin
          if_addr_q <= if_addr;
          d_addr_q  <= d_addr;
          d_wdata_q <= d_wdata;
          // A simultaneous read and write collapses to the write alone.
          wr_q      <= d_write;
          rd_q      <= d_read && !d_write;
          wait_cnt  <= '0;
        end
        S_DATA: begin
          if (acc_done) begin
            wait_cnt <= '0;
            if (rd_q) d_rdata <= bus.mem_ack ? bus.mem_rdata : 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_INSTR: begin
          if (acc_done) begin
            wait_cnt <= '0;
            // An abandoned fetch yields an all-zero word (NOP).
            if_rdata <= bus.mem_ack ? bus.mem_rdata : 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
      if (acc_abandon) timeout <= 1'b1;
    end
  end

endmodule
